dct_idct_sequencer: RTL and testbench

DCT_IDCT_SEQUENCER -- requirements
Module: dct_idct_sequencer

---
 rtl/dct_pkg.sv | 18 +
 rtl/apx_window.sv | 24 ++
 rtl/dct_idct_sequencer.sv | 156 +++++++++++++++
 tb/tb_dct_idct_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT/IDCT block sequencer.
package dct_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int unsigned BLOCK_SIZE = 64;
    localparam int unsigned CNT_W      = $clog2(BLOCK_SIZE);
    localparam int unsigned BLK_W      = 16;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned PIX_MSB    = 17;
    localparam int unsigned PIX_LSB    = 10;

endpackage

// File: rtl/apx_window.sv
// Flags whether the current block index lies in [APX_START, APX_END).
module apx_window
    import dct_pkg::*;
#(
    parameter int unsigned APX_START = 0,
    parameter int unsigned APX_END   = 0
) (
    input  logic [BLK_W-1:0] blk_count_i,
    output logic             apx_c_o
);

    localparam bit          WinEn = (APX_END > APX_START);
    localparam int unsigned Span  = WinEn ? (APX_END - APX_START) : 0;

    logic [31:0] offset_c;
    logic        borrow_c;
    logic [31:0] unused_diff_c;

    // Borrow out of (offset - Span) means offset < Span; indices below START wrap high.
    assign offset_c                  = 32'(blk_count_i) - 32'(APX_START);
    assign {borrow_c, unused_diff_c} = 33'(offset_c) - 33'(Span);
    assign apx_c_o                   = WinEn && borrow_c;

endmodule

// File: rtl/dct_idct_sequencer.sv
// Feeds 64-sample blocks into a DCT/IDCT pipeline, waits for the IDCT result,
// drains 64 output pixels and keeps a saturating completed-block count.
module dct_idct_sequencer
    import dct_pkg::*;
#(
    parameter int unsigned BitWidth  = 31,
    parameter int unsigned APX_START = 0,
    parameter int unsigned APX_END   = 0,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [BitWidth:0]    pix_data,
    output logic                 pix_ready,
    output logic                 dct_start,
    output logic [BitWidth:0]    dct_din,
    input  logic                 dct_reading,
    input  logic                 dct_done,
    input  logic                 idct_done,
    input  logic [BitWidth:0]    idct_dout,
    output logic                 rapx,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_pix,
    output logic [BLK_W-1:0]     blk_count,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               rapx_q, rapx_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_pix_q, out_pix_d;
    logic [BLK_W-1:0]   blk_count_q, blk_count_d;
    logic               timeout_err_q, timeout_err_d;
    logic               dct_start_q;
    logic               busy_q;
    logic               apx_c;
    logic               accept_c;
    logic               unused_c;

    apx_window #(
        .APX_START (APX_START),
        .APX_END   (APX_END)
    ) u_apx_window (
        .blk_count_i (blk_count_q),
        .apx_c_o     (apx_c)
    );

    // Handshake is combinational on dct_reading so the DCT can throttle per cycle.
    assign pix_ready = (state_q == LOAD) && dct_reading;
    assign accept_c  = pix_valid && pix_ready;
    assign dct_din   = pix_data;

    // dct_done is observed only; upper/lower idct_dout bits are not consumed.
    assign unused_c  = ^{dct_done, idct_dout};

    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        out_cnt_d     = out_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        rapx_d        = rapx_q;
        out_valid_d   = 1'b0;
        out_pix_d     = out_pix_q;
        blk_count_d   = blk_count_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (pix_valid) begin
                    state_d      = LOAD;
                    rapx_d       = apx_c;
                    sample_cnt_d = '0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (sample_cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
                        state_d    = WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            WAIT: begin
                if (idct_done) begin
                    state_d   = DRAIN;
                    out_cnt_d = '0;
                end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            DRAIN: begin
                // A low idct_done simply stalls the drain.
                if (idct_done) begin
                    out_valid_d = 1'b1;
                    out_pix_d   = idct_dout[PIX_MSB:PIX_LSB];
                    out_cnt_d   = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
                        state_d = IDLE;
                        if (blk_count_q != {BLK_W{1'b1}}) begin
                            blk_count_d = blk_count_q + BLK_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sample_cnt_q  <= '0;
            out_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            rapx_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pix_q     <= '0;
            blk_count_q   <= '0;
            timeout_err_q <= 1'b0;
            dct_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            out_cnt_q     <= out_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            rapx_q        <= rapx_d;
            out_valid_q   <= out_valid_d;
            out_pix_q     <= out_pix_d;
            blk_count_q   <= blk_count_d;
            timeout_err_q <= timeout_err_d;
            dct_start_q   <= (state_d == LOAD);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign dct_start   = dct_start_q;
    assign rapx        = rapx_q;
    assign out_valid   = out_valid_q;
    assign out_pix     = out_pix_q;
    assign blk_count   = blk_count_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dct_idct_sequencer.sv
// Scoreboard bench for dct_idct_sequencer: directed blocks, approximate window,
// WAIT timeout, mid-block reset and over-long idct_done.
module tb_dct_idct_sequencer;

    localparam int unsigned BW = 31;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0;
    logic [BW:0]   pix_data = '0;
    logic          pix_ready;
    logic          dct_start;
    logic [BW:0]   dct_din;
    logic          dct_reading = 1'b0;
    logic          dct_done = 1'b0;
    logic          idct_done = 1'b0;
    logic [BW:0]   idct_dout = '0;
    logic          rapx;
    logic          out_valid;
    logic [7:0]    out_pix;
    logic [15:0]   blk_count;
    logic          busy;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int out_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    dct_idct_sequencer #(
        .BitWidth  (BW),
        .APX_START (2),
        .APX_END   (4),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .dct_start   (dct_start),
        .dct_din     (dct_din),
        .dct_reading (dct_reading),
        .dct_done    (dct_done),
        .idct_done   (idct_done),
        .idct_dout   (idct_dout),
        .rapx        (rapx),
        .out_valid   (out_valid),
        .out_pix     (out_pix),
        .blk_count   (blk_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented pixel must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            out_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_extra: got out_pix=%0h expected no output", out_pix);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_pix !== mon_exp) begin
                    errors++;
                    $display("FAIL out_pix: got %0h expected %0h", out_pix, mon_exp);
                end
            end
        end
    end

    // Presents samples until n accepts; checks ready tracks dct_reading once in LOAD.
    task automatic load_block(input int n, input bit toggle, input logic [BW:0] val, input bit exp_rapx);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 400) begin
            @(negedge clk);
            pix_valid   = 1'b1;
            pix_data    = val;
            dct_reading = toggle ? cyc[0] : 1'b1;
            #1;
            if (cyc == 1) begin
                check("dct_start_load", 32'(dct_start), 1);
                check("rapx_load", 32'(rapx), 32'(exp_rapx));
                check("dct_din_pass", dct_din, val);
            end
            if (cyc > 0) check(dct_reading ? "ready_reading" : "ready_stalled", 32'(pix_ready), 32'(dct_reading));
            if (pix_ready) acc++;
            cyc++;
        end
        if (acc < n) check("load_budget", acc, n);
        if (n == 64) begin
            @(negedge clk);
            pix_valid   = 1'b0;
            dct_reading = 1'b1;
            #1;
            check("ready_after_64", 32'(pix_ready), 0);
            check("dct_start_wait", 32'(dct_start), 0);
            check("busy_wait", 32'(busy), 1);
        end
    endtask

    // First idct_done cycle moves WAIT->DRAIN; the next 64 produce pixels.
    task automatic drain(input int w, input int hold, input bit exp_rapx, input int exp_blk);
        int start = out_seen;
        for (int i = 0; i < w; i++) @(negedge clk);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            idct_done = 1'b1;
            idct_dout = 32'h8000_0000 | (32'(8'(k * 37 + 11)) << 10) | 32'h0000_0155;
            if (k >= 1 && k <= 64) exp_q.push_back(8'(k * 37 + 11));
            if (k == 32) begin
                #1;
                check("rapx_mid", 32'(rapx), 32'(exp_rapx));
            end
        end
        @(negedge clk);
        idct_done = 1'b0;
        idct_dout = '0;
        repeat (3) @(negedge clk);
        #1;
        check("out_count", out_seen - start, 64);
        check("queue_empty", exp_q.size(), 0);
        check("blk_count", 32'(blk_count), exp_blk);
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pix_ready"}, 32'(pix_ready), 0);
        check({tag, "_dct_start"}, 32'(dct_start), 0);
        check({tag, "_rapx"}, 32'(rapx), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_pix"}, 32'(out_pix), 0);
        check({tag, "_blk_count"}, 32'(blk_count), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_rapx_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int start_seen;

        dct_reading = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // dct_done alone must not start anything
        @(negedge clk);
        dct_done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("dct_done_idle_busy", 32'(busy), 0);
        dct_done = 1'b0;

        // Six blocks across the approximate window [2,4)
        for (int b = 0; b < 6; b++) begin
            load_block(64, (b == 1), 32'h5, exp_rapx_seq[b]);
            drain(2, (b == 1) ? 70 : 65, exp_rapx_seq[b], b + 1);
        end

        // WAIT timeout after 16 cycles without idct_done
        start_seen = out_seen;
        load_block(64, 1'b0, 32'h7, 1'b0);
        repeat (15) @(negedge clk);
        #1;
        check("timeout_before", 32'(timeout_err), 0);
        check("busy_wait16", 32'(busy), 1);
        @(negedge clk);
        #1;
        check("timeout_set", 32'(timeout_err), 1);
        check("busy_after_timeout", 32'(busy), 0);
        check("blk_after_timeout", 32'(blk_count), 6);
        check("no_out_on_timeout", out_seen - start_seen, 0);

        // Sticky error survives a good block
        load_block(64, 1'b0, 32'h3, 1'b0);
        drain(2, 65, 1'b0, 7);
        check("timeout_sticky", 32'(timeout_err), 1);

        // Reset after 30 samples abandons the block
        load_block(30, 1'b0, 32'h9, 1'b0);
        @(negedge clk);
        reset       = 1'b1;
        pix_valid   = 1'b0;
        dct_reading = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        load_block(64, 1'b0, 32'hA, 1'b0);
        drain(2, 65, 1'b0, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
